// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// | Module  : uart_pkg                                                       |
// | Brief   : Shared state encoding and frame constants for the UART TX.    |
// | Revision: 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } uart_state_e;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam int   UART_DATA_W     = 8;
  localparam int   UART_FRAME_BITS = UART_DATA_W + 2;

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// | Module  : baud_tick_gen                                                  |
// | Brief   : Free-running bit-period counter; tick marks the last cycle.   |
// | Revision: 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_terminal;

  assign w_at_terminal = (r_count == C_TERMINAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear || w_at_terminal) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = ~clear & w_at_terminal;

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// | Module  : fifo_uart_tx                                                   |
// | Brief   : Pops bytes from a sync FIFO and sends them as UART 8N1 frames.|
// | Revision: 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] C_LAST_BIT = IDX_W'(DATA_W - 1);

  uart_state_e       r_state;
  uart_state_e       w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [IDX_W-1:0]  w_bit_idx_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              w_tick;
  logic              w_baud_clear;
  logic              w_fetch_ok;

  // Counter only runs while a bit is on the wire, so it starts at 0 in START.
  assign w_baud_clear = (r_state != START) && (r_state != DATA) && (r_state != STOP);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (w_baud_clear),
    .tick   (w_tick)
  );

  assign w_fetch_ok = enable & ~fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= UART_STOP_BIT;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      IDLE: begin
        if (w_fetch_ok) w_state_next = FETCH;
      end
      FETCH: begin
        w_state_next = LOAD;
      end
      LOAD: begin
        w_shift_next = fifo_rd_data;
        w_state_next = START;
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
          if (r_bit_idx == C_LAST_BIT) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) w_state_next = w_fetch_ok ? FETCH : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // tx is decoded from the next state so the pad is driven straight from a flop.
  always_comb begin
    w_tx_next = UART_STOP_BIT;
    case (w_state_next)
      START:   w_tx_next = UART_START_BIT;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = UART_STOP_BIT;
    endcase
  end

  assign tx         = r_tx;
  assign fifo_rd_en = (r_state == FETCH);
  assign busy       = (r_state != IDLE);
  assign byte_done  = (r_state == STOP) & w_tick;

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8x8 synchronous FIFO.
- Pops one byte at a time from the FIFO read port and serialises it as UART 8N1: start bit, 8 data bits LSB first, one stop bit.
- Baud rate comes from a fixed clock divider.
- Drives the board TX pin; sits between the FIFO and the pad.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; legal range 2..65535.
- DATA_W, 8: byte width; must match the FIFO data width.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  permits fetching new bytes from the FIFO.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_W  FIFO data_out; valid one cycle after fifo_rd_en.
- fifo_rd_en  output  1  FIFO read strobe; one-cycle pulse per byte.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever state is not IDLE.
- byte_done  output  1  one-cycle pulse in the final cycle of each stop bit.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, tx=1, fifo_rd_en=0, busy=0, byte_done=0, baud counter=0, bit index=0, shift register=0.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately.
  - The byte already popped is lost (accepted).
- All outputs are registered or decoded from state flops; tx is glitch-free.
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If enable=1 and fifo_empty=0 at a rising edge, go to FETCH; otherwise stay.
- FETCH:
  - Exactly one cycle; fifo_rd_en=1.
  - Always go to LOAD.
  - fifo_empty is not re-sampled.
- LOAD:
  - Exactly one cycle; fifo_rd_data is captured into the shift register at the closing edge.
  - Go to START; clear the baud counter.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1; at the terminal count go to DATA with bit index=0.
- DATA:
  - tx = shift register bit 0.
  - At each terminal count, shift right and increment the bit index.
  - After DATA_W bits, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles; byte_done=1 in the last cycle.
  - At terminal count: if enable=1 and fifo_empty=0, go to FETCH (back-to-back); else go to IDLE.
- Timing:
  - Frame length is exactly (DATA_W+2)*CLKS_PER_BIT cycles.
  - Latency from the IDLE edge sampling a non-empty FIFO to the first start-bit cycle is 3 cycles (FETCH, LOAD, then START).
  - Back-to-back frames have exactly 2 extra tx-high cycles (FETCH+LOAD) between stop and next start.
- enable deasserted mid-frame: the current frame completes unchanged; no further fetch. Re-assertion in IDLE resumes.
- fifo_empty is only honoured in IDLE and at the STOP terminal count. fifo_rd_en is never asserted while fifo_empty=1 at the deciding edge, so the FIFO is never underflowed.
- Simultaneous FIFO write and this block's read is the FIFO's concern; this block issues at most one read per frame.
- Baud counter width is $clog2(CLKS_PER_BIT); it wraps to 0 at terminal count.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, START, DATA, STOP);
  - constants: UART_START_BIT=0, UART_STOP_BIT=1, UART_FRAME_BITS=DATA_W+2.
- One sub-module: baud_tick_gen (param CLKS_PER_BIT; inputs clk, reset_n, clear; output tick on terminal count).
- FSM and shift register live in fifo_uart_tx.

Test Plan (CLKS_PER_BIT=4, behavioural FIFO model with 1-cycle read latency):
- Reset held, FIFO non-empty -> tx=1, fifo_rd_en=0, busy=0 throughout; release -> first fifo_rd_en exactly 1 cycle after the first IDLE sample.
- Single byte 8'hA5, enable=1:
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; 40-cycle frame.
  - One fifo_rd_en pulse; one byte_done pulse in cycle 40; then IDLE.
- FIFO preloaded with 8'h12,8'h34,8'h56:
  - three frames decode to the same bytes in order;
  - exactly 2 tx-high cycles between consecutive frames;
  - exactly 3 fifo_rd_en pulses; FIFO ends empty, busy falls.
- enable dropped mid-frame on byte 8'hFF with 8'h00 still queued -> 8'hFF completes; no further fifo_rd_en; re-asserting enable sends 8'h00.
- reset_n pulsed low during DATA bit 3 of 8'h0F -> tx goes to 1 the same cycle; state IDLE; next queued byte transmits cleanly after release.
- fifo_empty=1 with enable=1 for 100 cycles -> no fifo_rd_en, tx=1, busy=0.
